dcache_ctrl_dm: RTL and testbench
=================================

// Module: dcache_ctrl_dm
// PURPOSE
//  Direct-mapped, write-through, no-write-allocate data cache controller.
//  Sits between the CPU load/store port and data_memory_delayed, acting as
//  the initiator of the memory rd_en/wr_en/ready protocol. Read hits return
//  in 1 cycle. Misses and all writes stall the CPU until the memory
//  transaction completes.
// PARAMETERS
//  DATA_WIDTH  32  word width; matches the memory
//  ADDR_WIDTH  32  word address width; matches the memory
//  NUM_LINES   16  cache lines, one word each; power of 2; IDX=log2(NUM_LINES)
// PORTS
//  clk         in   1           single clock; all state changes on posedge
//  reset       in   1           synchronous, active-high
//  cpu_rd      in   1           load request; held until cpu_done
//  cpu_wr      in   1           store request; held until cpu_done
//  cpu_addr    in   ADDR_WIDTH  word address; held until cpu_done
//  cpu_wdata   in   DATA_WIDTH  store data; held until cpu_done
//  cpu_rdata   out  DATA_WIDTH  load data; valid when cpu_done=1
//  cpu_done    out  1           one-cycle completion pulse
//  cpu_busy    out  1           high while a miss or write is outstanding
//  mem_rd_en   out  1           memory read request, one-cycle pulse
//  mem_wr_en   out  1           memory write request, one-cycle pulse
//  mem_address out  ADDR_WIDTH  memory address; held for the whole transaction
//  mem_wr_data out  DATA_WIDTH  memory write data; held until ready returns
//  mem_rd_data in   DATA_WIDTH  memory read data; valid once ready returns high
//  mem_ready   in   1           memory idle (low while a transfer is in flight)
//  hit_count   out  16          saturating read-hit counter
//  miss_count  out  16          saturating read-miss counter
// BEHAVIOUR
//  Reset: all valid bits=0, FSM=IDLE; all outputs 0, counters included.
//   Tag/data arrays are not cleared.
//  Address split: idx=cpu_addr[IDX-1:0], tag=cpu_addr[ADDR_WIDTH-1:IDX].
//  FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESPOND.
//  IDLE, cpu_rd, hit (valid[idx] && tag match):
//   - next cycle: cpu_rdata=line data, cpu_done=1; hit_count++.
//   - Stay in IDLE.
//  IDLE, cpu_rd, miss: latch addr; miss_count++; go to ISSUE (read).
//  IDLE, cpu_wr: latch addr and data; if hit, update line data this cycle;
//   a miss does not allocate. Go to ISSUE (write).
//  cpu_rd and cpu_wr both high: treat as a read; the write is ignored.
//  ISSUE:
//   - Wait for mem_ready=1, then assert mem_rd_en or mem_wr_en for exactly
//     one cycle; go to WAIT_BUSY.
//   - Never assert both enables together.
//  WAIT_BUSY: wait for mem_ready=0, then go to WAIT_DONE.
//  WAIT_DONE: on mem_ready=1, go to RESPOND.
//   - Read: capture mem_rd_data into line data, tag and valid, and into
//     cpu_rdata.
//  RESPOND: cpu_done=1 for one cycle; go to IDLE.
//   - A new request is accepted no earlier than the following cycle.
//  Memory latency is not hard-coded; completion is the ready low->high
//   edge only (about 22 cycles with the current memory).
//  mem_address and mem_wr_data stay constant from ISSUE through RESPOND,
//   because the memory samples write data at completion.
//  cpu_busy=1 in ISSUE, WAIT_BUSY and WAIT_DONE; 0 in IDLE and RESPOND.
//  cpu_done is never high in two consecutive cycles.
//  cpu_done is never asserted without a request having been accepted.
//  Counters saturate at 16'hFFFF; a write hit counts in neither counter.
//  Reset mid-transaction: FSM returns to IDLE, enables drop, valid bits
//   clear, and no cpu_done is issued. The memory shares the same reset.
// TESTING (memory initialised RAM[i]=i, NUM_LINES=16)
//  1. Cold read 0x05: one mem_rd_en pulse; cpu_done with cpu_rdata=5;
//     miss_count=1.
//  2. Reread 0x05: cpu_done on the next cycle with rdata=5 and no mem_rd_en;
//     hit_count=1.
//  3. Read 0x15 (same idx 5): miss; rdata=0x15. Then read 0x05: miss again
//     (eviction); miss_count=3.
//  4. Write 0x15<=0xABCD (hit):
//     - mem_wr_en pulses once; mem_wr_data stays 0xABCD until ready.
//     - Then read 0x15: hit, rdata=0xABCD.
//  5. Write 0x30<=7 (miss), then read 0x30: the write does not allocate;
//     the read misses and returns 7 from memory.
//  6. Assert reset while in WAIT_DONE:
//     - Outputs go to 0 and no cpu_done is issued.
//     - Read 0x05 after reset: miss, rdata=5.

Source files
------------

// File: rtl/dcache_ctrl_dm.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Read hits complete in one cycle; misses and all stores go to memory over the rd_en/wr_en/ready handshake.
module dcache_ctrl_dm #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_LINES  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_rd,
    input  logic                  cpu_wr,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_done,
    output logic                  cpu_busy,
    output logic                  mem_rd_en,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    input  logic                  mem_ready,
    output logic [15:0]           hit_count,
    output logic [15:0]           miss_count
);
    localparam int IDX   = $clog2(NUM_LINES);
    localparam int TAG_W = ADDR_WIDTH - IDX;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESPOND} state_t;

    state_t                  state;
    logic                    is_write;
    logic [DATA_WIDTH-1:0]   line_data [NUM_LINES];
    logic [TAG_W-1:0]        line_tag  [NUM_LINES];
    logic [NUM_LINES-1:0]    line_valid;

    logic [IDX-1:0]   idx;
    logic [TAG_W-1:0] tag;
    logic [IDX-1:0]   fill_idx;
    logic             hit;
    logic             accept;
    logic             write_hit;
    logic             fill;

    assign idx      = cpu_addr[IDX-1:0];
    assign tag      = cpu_addr[ADDR_WIDTH-1:IDX];
    assign fill_idx = mem_address[IDX-1:0];
    assign hit      = line_valid[idx] && (line_tag[idx] == tag);
    // The cycle carrying cpu_done still sees the finished request held, so it must not be taken again.
    assign accept    = (state == IDLE) && !cpu_done && (cpu_rd || cpu_wr);
    assign write_hit = accept && !cpu_rd && hit;
    assign fill      = (state == WAIT_DONE) && mem_ready && !is_write;

    // NOTE: tag/data storage has no reset; only the valid bits must be cleared for correctness.
    always_ff @(posedge clk) begin
        if (write_hit) begin
            line_data[idx] <= cpu_wdata;
        end else if (fill) begin
            line_data[fill_idx] <= mem_rd_data;
            line_tag[fill_idx]  <= mem_address[ADDR_WIDTH-1:IDX];
        end
    end

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            is_write    <= 1'b0;
            line_valid  <= '0;
            cpu_rdata   <= '0;
            cpu_done    <= 1'b0;
            cpu_busy    <= 1'b0;
            mem_rd_en   <= 1'b0;
            mem_wr_en   <= 1'b0;
            mem_address <= '0;
            mem_wr_data <= '0;
            hit_count   <= '0;
            miss_count  <= '0;
        end else begin
            cpu_done  <= 1'b0;
            mem_rd_en <= 1'b0;
            mem_wr_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && cpu_rd) begin
                        if (hit) begin
                            cpu_rdata <= line_data[idx];
                            cpu_done  <= 1'b1;
                            if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
                        end else begin
                            mem_address <= cpu_addr;
                            is_write    <= 1'b0;
                            cpu_busy    <= 1'b1;
                            state       <= ISSUE;
                            if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
                        end
                    end else if (accept) begin
                        mem_address <= cpu_addr;
                        mem_wr_data <= cpu_wdata;
                        is_write    <= 1'b1;
                        cpu_busy    <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mem_ready) begin
                        mem_wr_en <= is_write;
                        mem_rd_en <= !is_write;
                        state     <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY: begin
                    if (!mem_ready) state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (mem_ready) begin
                        if (!is_write) begin
                            cpu_rdata            <= mem_rd_data;
                            line_valid[fill_idx] <= 1'b1;
                        end
                        cpu_busy <= 1'b0;
                        cpu_done <= 1'b1;
                        state    <= RESPOND;
                    end
                end
                RESPOND: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dcache_ctrl_dm.sv
// Table-driven bench for dcache_ctrl_dm with a behavioural delayed memory (RAM[i]=i after reset).
module tb_dcache_ctrl_dm;
    localparam int LAT    = 20;
    localparam int BUDGET = 200;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_rd, cpu_wr;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_done, cpu_busy;
    logic        mem_rd_en, mem_wr_en, mem_ready;
    logic [31:0] mem_address, mem_wr_data, mem_rd_data;
    logic [15:0] hit_count, miss_count;

    dcache_ctrl_dm dut (
        .clk(clk), .reset(reset),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_busy(cpu_busy),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_address(mem_address),
        .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data), .mem_ready(mem_ready),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    // Memory model: accepts a pulse while ready, drops ready for LAT+1 cycles, completes on ready rising.
    logic [31:0] ram [256];
    int          lat_cnt;
    logic        pend_wr;
    always @(posedge clk) begin
        if (reset) begin
            mem_ready   <= 1'b1;
            mem_rd_data <= '0;
            lat_cnt     <= 0;
            pend_wr     <= 1'b0;
            for (int i = 0; i < 256; i++) ram[i] <= 32'(i);
        end else if (mem_ready) begin
            if (mem_rd_en || mem_wr_en) begin
                mem_ready <= 1'b0;
                lat_cnt   <= LAT;
                pend_wr   <= mem_wr_en;
            end
        end else if (lat_cnt == 0) begin
            mem_ready <= 1'b1;
            if (pend_wr) ram[mem_address[7:0]] <= mem_wr_data;
            else         mem_rd_data <= ram[mem_address[7:0]];
        end else begin
            lat_cnt <= lat_cnt - 1;
        end
    end

    // Protocol monitor
    int   rd_pulses = 0, wr_pulses = 0, done_pulses = 0;
    logic both_en_seen = 1'b0, done_twice_seen = 1'b0, prev_done = 1'b0;
    always @(negedge clk) begin
        if (mem_rd_en) rd_pulses++;
        if (mem_wr_en) wr_pulses++;
        if (cpu_done)  done_pulses++;
        if (mem_rd_en && mem_wr_en) both_en_seen = 1'b1;
        if (cpu_done && prev_done)  done_twice_seen = 1'b1;
        prev_done = cpu_done;
    end

    int n_checks = 0, n_fail = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_hit;
        int          exp_hits;
        int          exp_misses;
        int          exp_rdp;
        int          exp_wrp;
    } vec_t;

    // One CPU request; drives at negedge, samples at negedge, drops the request in the done cycle.
    task automatic run_req(input string tag, input vec_t v);
        int          cycles = 0;
        int          rdp0, wrp0;
        logic        got_done = 1'b0;
        logic        busy_seen = 1'b0;
        logic        wdata_ok = 1'b1;
        logic        busy_at_done = 1'b0;
        logic [31:0] rdata = '0;
        @(negedge clk);
        rdp0 = rd_pulses;
        wrp0 = wr_pulses;
        cpu_rd = v.rd; cpu_wr = v.wr; cpu_addr = v.addr; cpu_wdata = v.wdata;
        while (!got_done && cycles < BUDGET) begin
            @(negedge clk);
            cycles++;
            if (cpu_busy) busy_seen = 1'b1;
            if (v.wr && !v.rd && cpu_busy && mem_wr_data !== v.wdata) wdata_ok = 1'b0;
            if (cpu_done) begin
                got_done     = 1'b1;
                rdata        = cpu_rdata;
                busy_at_done = cpu_busy;
            end
        end
        cpu_rd = 1'b0; cpu_wr = 1'b0;
        check({tag, " done"}, 32'(got_done), 32'd1);
        if (v.rd) check({tag, " rdata"}, rdata, v.exp_rdata);
        check({tag, " one_cycle"}, 32'(cycles == 1), 32'(v.exp_hit));
        check({tag, " busy_seen"}, 32'(busy_seen), 32'(!v.exp_hit));
        check({tag, " busy_at_done"}, 32'(busy_at_done), 32'd0);
        check({tag, " hit_count"}, 32'(hit_count), 32'(v.exp_hits));
        check({tag, " miss_count"}, 32'(miss_count), 32'(v.exp_misses));
        check({tag, " rd_pulses"}, 32'(rd_pulses - rdp0), 32'(v.exp_rdp));
        check({tag, " wr_pulses"}, 32'(wr_pulses - wrp0), 32'(v.exp_wrp));
        if (v.wr && !v.rd) check({tag, " wdata_held"}, 32'(wdata_ok), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " cpu_done"}, 32'(cpu_done), 32'd0);
        check({tag, " cpu_busy"}, 32'(cpu_busy), 32'd0);
        check({tag, " mem_rd_en"}, 32'(mem_rd_en), 32'd0);
        check({tag, " mem_wr_en"}, 32'(mem_wr_en), 32'd0);
        check({tag, " cpu_rdata"}, cpu_rdata, 32'd0);
        check({tag, " mem_address"}, mem_address, 32'd0);
        check({tag, " hit_count"}, 32'(hit_count), 32'd0);
        check({tag, " miss_count"}, 32'(miss_count), 32'd0);
    endtask

    vec_t vecs [15];
    vec_t post [3];

    initial begin
        //           rd    wr    addr    wdata   rdata   hit   h  m  rp wp
        vecs[0]  = '{1'b1, 1'b0, 32'h05, 32'h0,  32'h5,  1'b0, 0, 1, 1, 0}; // cold miss
        vecs[1]  = '{1'b1, 1'b0, 32'h05, 32'h0,  32'h5,  1'b1, 1, 1, 0, 0}; // hit
        vecs[2]  = '{1'b1, 1'b0, 32'h15, 32'h0,  32'h15, 1'b0, 1, 2, 1, 0}; // conflict on idx 5
        vecs[3]  = '{1'b1, 1'b0, 32'h05, 32'h0,  32'h5,  1'b0, 1, 3, 1, 0}; // evicted
        vecs[4]  = '{1'b1, 1'b0, 32'h15, 32'h0,  32'h15, 1'b0, 1, 4, 1, 0};
        vecs[5]  = '{1'b0, 1'b1, 32'h15, 32'hABCD, 32'h0, 1'b0, 1, 4, 0, 1}; // write hit
        vecs[6]  = '{1'b1, 1'b0, 32'h15, 32'h0,  32'hABCD, 1'b1, 2, 4, 0, 0};
        vecs[7]  = '{1'b0, 1'b1, 32'h30, 32'h7,  32'h0,  1'b0, 2, 4, 0, 1}; // write miss, no allocate
        vecs[8]  = '{1'b1, 1'b0, 32'h30, 32'h0,  32'h7,  1'b0, 2, 5, 1, 0};
        vecs[9]  = '{1'b1, 1'b0, 32'h30, 32'h0,  32'h7,  1'b1, 3, 5, 0, 0};
        vecs[10] = '{1'b0, 1'b1, 32'h25, 32'h1234, 32'h0, 1'b0, 3, 5, 0, 1}; // write miss keeps line 5
        vecs[11] = '{1'b1, 1'b0, 32'h15, 32'h0,  32'hABCD, 1'b1, 4, 5, 0, 0};
        vecs[12] = '{1'b1, 1'b0, 32'h25, 32'h0,  32'h1234, 1'b0, 4, 6, 1, 0};
        vecs[13] = '{1'b1, 1'b1, 32'h07, 32'hDEAD, 32'h7, 1'b0, 4, 7, 1, 0}; // rd+wr acts as read
        vecs[14] = '{1'b1, 1'b0, 32'h07, 32'h0,  32'h7,  1'b1, 5, 7, 0, 0};
        post[0]  = '{1'b1, 1'b0, 32'h07, 32'h0,  32'h7,  1'b0, 0, 1, 1, 0}; // valid cleared by reset
        post[1]  = '{1'b1, 1'b0, 32'h05, 32'h0,  32'h5,  1'b0, 0, 2, 1, 0};
        post[2]  = '{1'b1, 1'b0, 32'h05, 32'h0,  32'h5,  1'b1, 1, 2, 0, 0};

        reset = 1'b1; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_reset_outputs("init");

        for (int i = 0; i < 15; i++) run_req($sformatf("v%0d", i), vecs[i]);

        // Reset while the memory read is in flight.
        begin
            int   waited = 0;
            int   done0;
            @(negedge clk);
            cpu_rd = 1'b1; cpu_addr = 32'h35;
            while (mem_ready && waited < BUDGET) begin
                @(negedge clk);
                waited++;
            end
            check("mid_reset ready_low", 32'(mem_ready), 32'd0);
            repeat (3) @(negedge clk);
            check("mid_reset busy_before", 32'(cpu_busy), 32'd1);
            reset = 1'b1; cpu_rd = 1'b0;
            @(negedge clk);
            reset = 1'b0;
            check_reset_outputs("mid_reset");
            done0 = done_pulses;
            repeat (40) @(negedge clk);
            check("mid_reset no_done", 32'(done_pulses - done0), 32'd0);
            check("mid_reset idle_busy", 32'(cpu_busy), 32'd0);
        end

        for (int i = 0; i < 3; i++) run_req($sformatf("post%0d", i), post[i]);

        check("both_enables_never", 32'(both_en_seen), 32'd0);
        check("done_never_twice", 32'(done_twice_seen), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
